// File: rtl/pit_bus_master.sv
// Host-side initiator that runs one 8254 bus cycle (setup/strobe/hold) per request.
// Optional macro PIT_BUS_RECOVERY_EN adds a RECOVER phase of idle bus time after each cycle.
module pit_bus_master #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       A0,
  output logic       A1,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in
);

  localparam logic [3:0] L_SET = 4'(SETUP_CYC - 1);
  localparam logic [3:0] L_STB = 4'(STROBE_CYC - 1);
  localparam logic [3:0] L_HLD = 4'(HOLD_CYC - 1);
  localparam logic [3:0] L_REC = 4'(RECOVERY_CYC - 1);

`ifdef PIT_BUS_RECOVERY_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
  logic w_unused_rec;
  assign w_unused_rec = ^L_REC;
`endif

  state_t     r_state, w_next;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_write;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdcap;
  logic       w_accept, w_err_req, w_cnt_done, w_bus;

  assign w_accept   = req_valid && req_ready;
  // A read of the control word is illegal on the 8254: answer at once, no bus cycle.
  assign w_err_req  = !req_write && (req_addr == 2'd3);
  assign w_cnt_done = (r_cnt == 4'd0);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = w_cnt_done ? 4'd0 : r_cnt - 4'd1;
    case (r_state)
      S_IDLE:
        if (w_accept && !w_err_req) begin
          w_next    = S_SETUP;
          w_cnt_nxt = L_SET;
        end
      S_SETUP:
        if (w_cnt_done) begin
          w_next    = S_STROBE;
          w_cnt_nxt = L_STB;
        end
      S_STROBE:
        if (w_cnt_done) begin
          w_next    = S_HOLD;
          w_cnt_nxt = L_HLD;
        end
      S_HOLD:
        if (w_cnt_done) begin
`ifdef PIT_BUS_RECOVERY_EN
          w_next    = S_RECOVER;
          w_cnt_nxt = L_REC;
`else
          w_next    = S_IDLE;
`endif
        end
`ifdef PIT_BUS_RECOVERY_EN
      S_RECOVER:
        if (w_cnt_done) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Bus pins decode straight from registered state, so they are glitch-free per phase.
  always_comb begin
    w_bus     = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
    req_ready = (r_state == S_IDLE);
    CS        = !w_bus;
    A1        = w_bus ? r_addr[1] : 1'b0;
    A0        = w_bus ? r_addr[0] : 1'b0;
    RD        = !((r_state == S_STROBE) && !r_write);
    WR        = !((r_state == S_STROBE) && r_write);
    D_oe      = w_bus && r_write;
    D_out     = (w_bus && r_write) ? r_wdata : 8'h00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 2'd0;
      r_wdata   <= 8'h00;
      r_rdcap   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      rsp_valid <= 1'b0;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        if (w_err_req) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= 8'h00;
        end
      end
      // Capture on the last RD-low cycle, when timer data is settled longest.
      if ((r_state == S_STROBE) && w_cnt_done && !r_write)
        r_rdcap <= D_in;
      if ((r_state == S_HOLD) && w_cnt_done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= r_write ? 8'h00 : r_rdcap;
      end
    end
  end

endmodule

// File: tb/tb_pit_bus_master.sv
// Directed self-checking bench for pit_bus_master at default parameters.
module tb_pit_bus_master;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'h00, D_in = 8'h00;
  logic       req_ready, rsp_valid, rsp_err, A0, A1, CS, RD, WR, D_oe;
  logic [7:0] rsp_rdata, D_out;
  int         total = 0, bad = 0;

`ifdef PIT_BUS_RECOVERY_EN
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_GAP = 1;
`endif

  pit_bus_master dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .A0(A0), .A1(A1), .CS(CS), .RD(RD), .WR(WR),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({CS, RD, WR, D_oe, req_ready, rsp_valid, rsp_err, A1, A0} !== 9'b111_0_1_0_0_00 ||
          D_out !== 8'h00 || rsp_rdata !== 8'h00) begin
        bad++;
        $display("FAIL reset cyc%0d: CS%b RD%b WR%b oe%b rdy%b rv%b err%b A%b%b dout=%h rdata=%h, want 1110100 00 00 00",
                 k, CS, RD, WR, D_oe, req_ready, rsp_valid, rsp_err, A1, A0, D_out, rsp_rdata);
      end
    end
  endtask

  task automatic test_write();
    logic exp_cs, exp_wr, exp_rv;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd3; req_wdata = 8'h34;
    step();
    // Change request inputs after accept; the latched copy must drive the bus.
    req_valid = 1'b0; req_addr = 2'd0; req_wdata = 8'hFF; req_write = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_cs = !(k <= 4);
      exp_wr = !(k == 2 || k == 3);
      exp_rv = (k == 5);
      total++;
      if (CS !== exp_cs || WR !== exp_wr || RD !== 1'b1 || D_oe !== !exp_cs ||
          D_out !== (exp_cs ? 8'h00 : 8'h34) || (!exp_cs && {A1, A0} !== 2'b11) ||
          rsp_valid !== exp_rv || (exp_rv && (rsp_err !== 1'b0 || rsp_rdata !== 8'h00))) begin
        bad++;
        $display("FAIL write cyc%0d: CS%b WR%b RD%b oe%b dout=%h A%b%b rv%b err%b rd=%h, want CS%b WR%b RD1 oe%b rv%b",
                 k, CS, WR, RD, D_oe, D_out, A1, A0, rsp_valid, rsp_err, rsp_rdata, exp_cs, exp_wr, !exp_cs, exp_rv);
      end
      step();
    end
  endtask

  task automatic test_read();
    logic exp_cs, exp_rd, exp_rv;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; req_wdata = 8'h00;
    D_in = 8'h3C;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      D_in = (k == 2 || k == 3) ? 8'hA5 : 8'h3C;
      exp_cs = !(k <= 4);
      exp_rd = !(k == 2 || k == 3);
      exp_rv = (k == 5);
      total++;
      if (CS !== exp_cs || RD !== exp_rd || WR !== 1'b1 || D_oe !== 1'b0 ||
          (!exp_cs && {A1, A0} !== 2'b01) || rsp_valid !== exp_rv ||
          (k >= 5 && rsp_rdata !== 8'hA5) || (exp_rv && rsp_err !== 1'b0)) begin
        bad++;
        $display("FAIL read cyc%0d: CS%b RD%b WR%b oe%b A%b%b rv%b err%b rd=%h, want CS%b RD%b WR1 oe0 A01 rv%b rd=a5",
                 k, CS, RD, WR, D_oe, A1, A0, rsp_valid, rsp_err, rsp_rdata, exp_cs, exp_rd, exp_rv);
      end
      step();
    end
  endtask

  task automatic test_read_err();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || CS !== 1'b1 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rderr rsp: rv%b err%b rd=%h CS%b rdy%b, want rv1 err1 rd=00 CS1 rdy1",
               rsp_valid, rsp_err, rsp_rdata, CS, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (rsp_valid !== 1'b0 || CS !== 1'b1 || RD !== 1'b1) begin
        bad++;
        $display("FAIL rderr after%0d: rv%b CS%b RD%b, want rv0 CS1 RD1", k, rsp_valid, CS, RD);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, runs = 0, gap = 0, lows = 0, rsps = 0;
    logic prev_cs = 1'b1;
    logic seen10 = 1'b0, seen27 = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h10;
    for (int c = 0; c < 20; c++) begin
      if (CS === 1'b0) begin
        lows++;
        if (prev_cs) runs++;
        if (runs == 1 && D_out === 8'h10) seen10 = 1'b1;
        if (runs == 2 && D_out === 8'h27) seen27 = 1'b1;
      end else if (runs == 1) gap++;
      if (rsp_valid === 1'b1) rsps++;
      prev_cs = CS;
      if (req_valid && req_ready) acc++;
      step();
      if (acc == 1) req_wdata = 8'h27;
      if (acc == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total++;
    if (gap !== EXP_GAP) begin
      bad++;
      $display("FAIL b2b gap: got %0d CS-high cycles, want %0d", gap, EXP_GAP);
    end
    total++;
    if (runs !== 2 || lows !== 8 || acc !== 2 || rsps !== 2) begin
      bad++;
      $display("FAIL b2b shape: runs=%0d lows=%0d acc=%0d rsps=%0d, want 2 8 2 2", runs, lows, acc, rsps);
    end
    total++;
    if (!(seen10 && seen27)) begin
      bad++;
      $display("FAIL b2b data: seen10=%b seen27=%b, want 1 1", seen10, seen27);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2; D_in = 8'h77;
    step();
    req_valid = 1'b0;
    step();
    total++;
    if (RD !== 1'b0 || CS !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid pre: RD%b CS%b, want RD0 CS0 in strobe", RD, CS);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++;
    if (RD !== 1'b1 || CS !== 1'b1 || WR !== 1'b1 || D_oe !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid post: RD%b CS%b WR%b oe%b rv%b rdy%b, want 1 1 1 0 0 1",
               RD, CS, WR, D_oe, rsp_valid, req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (rsp_valid !== 1'b0 || CS !== 1'b1) begin
        bad++;
        $display("FAIL rst_mid idle%0d: rv%b CS%b, want rv0 CS1", k, rsp_valid, CS);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, want finish earlier");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_err();
    test_back_to_back();
    step(); step(); step();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
